voice_mixer: RTL and testbench

- Upstream neighbour of the delta-sigma DAC.
- Collects one signed sample per voice for each sample frame and sums them.
- Applies the 4-bit master volume with a serial shift-add multiplier, then saturates the result to 14 bits.
- Presents one audio sample plus a single-cycle valid strobe that drives the DAC's audio_i and audio_valid_i inputs.

---
 rtl/audio_pkg.sv | 33 +++
 rtl/voice_mixer.sv | 136 +++++++++++++
 tb/tb_voice_mixer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions for the voice mixer and the delta-sigma DAC:
// mixer FSM states, output sample width and the output saturation helper.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    OUT
  } mix_state_e;

  localparam int AUDIO_W    = 14;
  localparam int AUDIO_MAX  = 8191;
  localparam int AUDIO_MIN  = -8192;
  localparam int MIX_PROD_W = 19;

  // Clamp a scaled mixer product into the signed AUDIO_W output range.
  function automatic logic signed [AUDIO_W-1:0] sat_audio(
    input logic signed [MIX_PROD_W-1:0] v
  );
    logic signed [MIX_PROD_W-1:0] hi;
    logic signed [MIX_PROD_W-1:0] lo;
    hi = MIX_PROD_W'(AUDIO_MAX);
    lo = MIX_PROD_W'(AUDIO_MIN);
    if (v > hi) begin
      return AUDIO_W'(AUDIO_MAX);
    end else if (v < lo) begin
      return AUDIO_W'(AUDIO_MIN);
    end
    return v[AUDIO_W-1:0];
  endfunction

endpackage

// File: rtl/voice_mixer.sv
// Sums one signed sample per voice per frame, scales by volume/8 with a serial
// shift-add multiplier and presents a saturated sample with a one-cycle strobe.
module voice_mixer
  import audio_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_W    = 12,
  parameter int VOL_W      = 4,
  parameter int OUT_W      = AUDIO_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  frame_start_i,
  input  logic                  voice_valid_i,
  output logic                  voice_ready_o,
  input  logic [VOICE_W-1:0]    voice_i,
  input  logic [1:0]            voice_idx_i,
  input  logic [NUM_VOICES-1:0] voice_mute_i,
  input  logic [VOL_W-1:0]      volume_i,
  output logic [OUT_W-1:0]      audio_o,
  output logic                  audio_valid_o,
  output logic                  overrun_o
);

  // Three guard bits keep a four-voice sum of full-scale samples from wrapping.
  localparam int ACC_W  = VOICE_W + 3;
  localparam int PROD_W = ACC_W + VOL_W;
  localparam int CNT_W  = 3;
  localparam int STEP_W = (VOL_W > 1) ? $clog2(VOL_W) : 1;

  mix_state_e state_q, state_d;

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [PROD_W-1:0] prod_q;
  logic [CNT_W-1:0]         voice_cnt_q;
  logic [STEP_W-1:0]        step_q;
  logic [VOL_W-1:0]         vol_q;

  logic                     xfer;
  logic                     mute_hit;
  logic                     last_voice;
  logic                     last_step;
  logic [3:0]               mute_pad;
  logic signed [ACC_W-1:0]  voice_ext;
  logic signed [PROD_W-1:0] acc_ext;
  logic signed [PROD_W-1:0] prod_shr;

  assign voice_ready_o = (state_q == ACCUM);
  assign xfer          = voice_ready_o & voice_valid_i;

  // Indices beyond NUM_VOICES land on zero-padded bits and are never muted.
  assign mute_pad   = 4'(voice_mute_i);
  assign mute_hit   = mute_pad[voice_idx_i];
  assign voice_ext  = {{(ACC_W-VOICE_W){voice_i[VOICE_W-1]}}, voice_i};
  assign acc_ext    = {{VOL_W{acc_q[ACC_W-1]}}, acc_q};
  assign prod_shr   = prod_q >>> (VOL_W - 1);
  assign last_voice = (voice_cnt_q == CNT_W'(NUM_VOICES - 1));
  assign last_step  = (step_q == STEP_W'(VOL_W - 1));

  // NOTE: synchronous reset -- rst_ni is only looked at on the rising clock edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start_i) state_d = ACCUM;
      ACCUM:   if (xfer && last_voice) state_d = SCALE;
      SCALE:   if (last_step) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The result is registered on the edge that closes OUT, so the strobe lands
  // VOL_W+1 cycles after the edge that accepted the last voice.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_ni) begin
      acc_q         <= '0;
      prod_q        <= '0;
      voice_cnt_q   <= '0;
      step_q        <= '0;
      vol_q         <= '0;
      audio_o       <= '0;
      audio_valid_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      audio_valid_o <= 1'b0;
      if (frame_start_i && (state_q != IDLE)) begin
        overrun_o <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (frame_start_i) begin
            acc_q       <= '0;
            prod_q      <= '0;
            voice_cnt_q <= '0;
            step_q      <= '0;
          end
        end
        ACCUM: begin
          if (xfer) begin
            if (!mute_hit) begin
              acc_q <= acc_q + voice_ext;
            end
            voice_cnt_q <= voice_cnt_q + 1'b1;
            if (last_voice) begin
              vol_q  <= volume_i;
              step_q <= '0;
            end
          end
        end
        SCALE: begin
          if (vol_q[step_q]) begin
            prod_q <= prod_q + (acc_ext <<< step_q);
          end
          step_q <= step_q + 1'b1;
        end
        OUT: begin
          audio_o       <= OUT_W'(sat_audio(prod_shr));
          audio_valid_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: a table of single-frame vectors plus
// hand-written sequences for overrun, idle inputs, reset and volume latching.
module tb_voice_mixer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        frame_start_i;
  logic        voice_valid_i;
  logic        voice_ready_o;
  logic [11:0] voice_i;
  logic [1:0]  voice_idx_i;
  logic [2:0]  voice_mute_i;
  logic [3:0]  volume_i;
  logic [13:0] audio_o;
  logic        audio_valid_o;
  logic        overrun_o;

  int n_vec = 0;
  int n_err = 0;

  voice_mixer dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .frame_start_i (frame_start_i),
    .voice_valid_i (voice_valid_i),
    .voice_ready_o (voice_ready_o),
    .voice_i       (voice_i),
    .voice_idx_i   (voice_idx_i),
    .voice_mute_i  (voice_mute_i),
    .volume_i      (volume_i),
    .audio_o       (audio_o),
    .audio_valid_o (audio_valid_o),
    .overrun_o     (overrun_o)
  );

  always #10 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] vol;
    logic [2:0] mute;
    int         v0, v1, v2;
    int         i0, i1, i2;
    int         exp;
    string      name;
  } vec_t;

  vec_t vecs[9];

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One complete frame; optionally pulses frame_start_i mid-ACCUM or bumps the
  // volume right after the latch edge. Checks ready, latency, value and width.
  task automatic do_frame(input logic [3:0] vol, input logic [2:0] mute,
                          input int v0, input int v1, input int v2,
                          input int i0, input int i1, input int i2,
                          input int exp, input string name,
                          input bit fs_in_accum, input bit vol_bump);
    int v[3];
    int ix[3];
    int n;
    v[0] = v0; v[1] = v1; v[2] = v2;
    ix[0] = i0; ix[1] = i1; ix[2] = i2;
    volume_i      = vol;
    voice_mute_i  = mute;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    check({name, " ready"}, int'(voice_ready_o), 1);
    for (int k = 0; k < 3; k++) begin
      voice_valid_i = 1'b1;
      voice_i       = 12'(v[k]);
      voice_idx_i   = 2'(ix[k]);
      if (k == 1 && fs_in_accum) frame_start_i = 1'b1;
      tick();
      frame_start_i = 1'b0;
    end
    voice_valid_i = 1'b0;
    if (vol_bump) volume_i = 4'd15;
    n = 0;
    while (!audio_valid_o && n < 20) begin
      tick();
      n++;
    end
    check({name, " latency"}, n, 5);
    check({name, " audio"}, int'($signed(audio_o)), exp);
    tick();
    check({name, " strobe width"}, int'(audio_valid_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int strobes;

    vecs[0] = '{4'd8,  3'b000, 1000, -200, 300, 0, 1, 2, 1100,   "basic"};
    vecs[1] = '{4'd15, 3'b000, 2047, 2047, 2047, 0, 1, 2, 8191,  "sat_pos"};
    vecs[2] = '{4'd15, 3'b000, -2048, -2048, -2048, 0, 1, 2, -8192, "sat_neg"};
    vecs[3] = '{4'd8,  3'b010, 500, 700, -100, 0, 1, 2, 400,     "mute"};
    vecs[4] = '{4'd0,  3'b000, 123, 456, 789, 0, 1, 2, 0,        "vol0"};
    vecs[5] = '{4'd1,  3'b000, -1, 0, 0, 0, 1, 2, -1,            "floor"};
    vecs[6] = '{4'd3,  3'b000, 100, 7, 0, 0, 1, 2, 40,           "vol3"};
    vecs[7] = '{4'd5,  3'b000, -13, 0, 0, 0, 1, 2, -9,           "vol5_neg"};
    vecs[8] = '{4'd8,  3'b001, 10, 20, 30, 0, 0, 2, 30,          "dup_idx"};

    rst_ni        = 1'b0;
    frame_start_i = 1'b0;
    voice_valid_i = 1'b0;
    voice_i       = '0;
    voice_idx_i   = '0;
    voice_mute_i  = '0;
    volume_i      = '0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    check("reset audio", int'($signed(audio_o)), 0);
    check("reset valid", int'(audio_valid_o), 0);
    check("reset overrun", int'(overrun_o), 0);
    check("reset ready", int'(voice_ready_o), 0);

    for (int i = 0; i < 9; i++) begin
      do_frame(vecs[i].vol, vecs[i].mute, vecs[i].v0, vecs[i].v1, vecs[i].v2,
               vecs[i].i0, vecs[i].i1, vecs[i].i2, vecs[i].exp, vecs[i].name,
               1'b0, 1'b0);
    end
    check("overrun quiet", int'(overrun_o), 0);

    // voice_valid_i while idle: never ready, nothing moves, no strobe.
    voice_valid_i = 1'b1;
    voice_i       = 12'd2000;
    strobes       = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (voice_ready_o) strobes++;
      if (audio_valid_o) strobes++;
    end
    check("idle ignores voice", strobes, 0);

    // Frame start and voice valid together: the 2000 sample must not be taken.
    volume_i      = 4'd8;
    voice_mute_i  = 3'b000;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    voice_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      voice_valid_i = 1'b1;
      voice_i       = 12'd1;
      voice_idx_i   = 2'(k);
      tick();
    end
    voice_valid_i = 1'b0;
    strobes = 0;
    while (!audio_valid_o && strobes < 20) begin
      tick();
      strobes++;
    end
    check("start+valid latency", strobes, 5);
    check("start+valid audio", int'($signed(audio_o)), 3);
    tick();

    do_frame(4'd8, 3'b000, 1000, -200, 300, 0, 1, 2, 1100, "overrun_frame", 1'b1, 1'b0);
    check("overrun set", int'(overrun_o), 1);
    do_frame(4'd2, 3'b000, 800, 0, 0, 0, 1, 2, 200, "vol_latch", 1'b0, 1'b1);
    check("overrun sticky", int'(overrun_o), 1);

    // Reset during SCALE aborts the frame silently.
    volume_i      = 4'd8;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      voice_valid_i = 1'b1;
      voice_i       = 12'd500;
      voice_idx_i   = 2'(k);
      tick();
    end
    voice_valid_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b0;
    tick();
    check("midreset audio", int'($signed(audio_o)), 0);
    check("midreset valid", int'(audio_valid_o), 0);
    check("midreset ready", int'(voice_ready_o), 0);
    check("midreset overrun", int'(overrun_o), 0);
    rst_ni  = 1'b1;
    strobes = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (audio_valid_o) strobes++;
    end
    check("midreset no strobe", strobes, 0);
    do_frame(4'd8, 3'b000, 1, 1, 1, 0, 1, 2, 3, "post_reset", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
